// File: rtl/bus_irq_controller_pkg.sv
// -----------------------------------------------------------------------------
// bus_irq_controller_pkg
//   Shared parameter header for the memory-mapped bus peripherals.
//   Holds the default base address, the register byte offsets of the interrupt
//   controller window, the timer-control bit positions and a byte-lane merge
//   helper used for partial-word writes.
// -----------------------------------------------------------------------------
package bus_irq_controller_pkg;

    localparam logic [31:0] BUS_IRQ_BASE_ADDR_DEFAULT = 32'hFF20_0300;

    localparam int unsigned IRQ_N   = 8;
    localparam int unsigned TIMER_W = 32;

    // Register byte offsets inside the 7-word window
    localparam logic [7:0] OFS_STATUS = 8'h00;
    localparam logic [7:0] OFS_MASK   = 8'h04;
    localparam logic [7:0] OFS_CLEAR  = 8'h08;
    localparam logic [7:0] OFS_MODE   = 8'h0C;
    localparam logic [7:0] OFS_TLOAD  = 8'h10;
    localparam logic [7:0] OFS_TCOUNT = 8'h14;
    localparam logic [7:0] OFS_TCTRL  = 8'h18;

    // Word index form of the offsets, as decoded from address bits [4:2]
    typedef enum logic [2:0] {
        REG_STATUS = 3'(OFS_STATUS >> 2),
        REG_MASK   = 3'(OFS_MASK   >> 2),
        REG_CLEAR  = 3'(OFS_CLEAR  >> 2),
        REG_MODE   = 3'(OFS_MODE   >> 2),
        REG_TLOAD  = 3'(OFS_TLOAD  >> 2),
        REG_TCOUNT = 3'(OFS_TCOUNT >> 2),
        REG_TCTRL  = 3'(OFS_TCTRL  >> 2)
    } irq_reg_e;

    localparam logic [2:0] REG_LAST_IDX = 3'(OFS_TCTRL >> 2);

    // TCTRL bit positions
    localparam int unsigned TCTRL_EN_BIT = 0;
    localparam int unsigned TCTRL_AR_BIT = 1;

    // Replace the bytes of old_val whose lane enable is set
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bus_irq_controller_timer.sv
// -----------------------------------------------------------------------------
// irq_timer
//   Down-counting interval timer for the interrupt controller.
//   Ports:
//     i_clk, i_rst      clock, synchronous active-high reset
//     i_load            load strobe (TLOAD write), overrides counting
//     i_load_val        value loaded on i_load
//     i_reload_val      value reloaded on expiry in auto-reload mode
//     i_enable          count enable
//     i_auto_reload     reload on expiry instead of stopping
//     o_count           current count
//     o_expire          one-cycle pulse while enabled at count zero
// -----------------------------------------------------------------------------
module irq_timer
    import bus_irq_controller_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic [TIMER_W-1:0] i_reload_val,
    input  logic               i_enable,
    input  logic               i_auto_reload,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_expire
);

    logic [TIMER_W-1:0] r_count;

    assign o_count  = r_count;
    // Expiry is the cycle spent at zero, so the period is reload value + 1
    assign o_expire = i_enable && (r_count == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable) begin
            if (r_count != '0) begin
                r_count <= r_count - TIMER_W'(1);
            end else if (i_auto_reload) begin
                r_count <= i_reload_val;
            end
        end
    end

endmodule

// File: rtl/bus_irq_controller.sv
// -----------------------------------------------------------------------------
// bus_irq_controller
//   Memory-mapped interrupt controller with 8 synchronized sources, per-line
//   edge/level mode, mask, write-1-to-clear and an interval timer on line 7.
//   Ports:
//     iCLK, iRST          clock, synchronous active-high reset
//     DwReadEnable        CPU read strobe (combinational read data)
//     DwWriteEnable       CPU write strobe
//     DwByteEnable[3:0]   write byte lanes
//     DwAddress[31:0]     byte address
//     DwWriteData[31:0]   write data
//     DwReadData[31:0]    read data, high-Z unless a selected read
//     iIrqSrc[7:0]        asynchronous interrupt sources
//     oPendingInterrupt   registered pending & MASK
// -----------------------------------------------------------------------------
module bus_irq_controller
    import bus_irq_controller_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BUS_IRQ_BASE_ADDR_DEFAULT
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    input  logic [7:0]  iIrqSrc,
    output logic [7:0]  oPendingInterrupt
);

    // Source synchronizer and edge-detect delay
    logic [IRQ_N-1:0]   r_sync1;
    logic [IRQ_N-1:0]   r_sync2;
    logic [IRQ_N-1:0]   r_dly;

    // Architectural state
    logic [IRQ_N-1:0]   r_pending;
    logic [IRQ_N-1:0]   r_mask;
    logic [IRQ_N-1:0]   r_mode;
    logic [TIMER_W-1:0] r_tload;
    logic [1:0]         r_tctrl;
    logic               r_exp_sticky;
    logic [IRQ_N-1:0]   r_irq_out;

    // Decode
    irq_reg_e           w_reg;
    logic               w_sel;
    logic               w_wr;
    logic               w_wr_lane0;
    logic               w_wr_mask;
    logic               w_wr_clear;
    logic               w_wr_mode;
    logic               w_wr_tload;
    logic               w_wr_tctrl;
    logic [TIMER_W-1:0] w_tload_merged;
    logic [31:0]        w_rd_data;
    logic               w_unused_addr;

    // Pending update
    logic [IRQ_N-1:0]   w_clr;
    logic [IRQ_N-1:0]   w_rise;
    logic [IRQ_N-1:0]   w_edge_nxt;
    logic [IRQ_N-1:0]   w_level_nxt;
    logic [IRQ_N-1:0]   w_pending_nxt;
    logic               w_sticky_nxt;

    // Timer
    logic [TIMER_W-1:0] w_tcount;
    logic               w_expire;

    assign w_unused_addr = ^DwAddress[1:0];

    assign w_reg = irq_reg_e'(DwAddress[4:2]);
    assign w_sel = (DwAddress[31:5] == BASE_ADDR[31:5]) &&
                   (DwAddress[4:2] <= REG_LAST_IDX);

    assign w_wr       = DwWriteEnable && w_sel;
    assign w_wr_lane0 = w_wr && DwByteEnable[0];
    assign w_wr_mask  = w_wr_lane0 && (w_reg == REG_MASK);
    assign w_wr_clear = w_wr_lane0 && (w_reg == REG_CLEAR);
    assign w_wr_mode  = w_wr_lane0 && (w_reg == REG_MODE);
    assign w_wr_tctrl = w_wr_lane0 && (w_reg == REG_TCTRL);
    assign w_wr_tload = w_wr && (w_reg == REG_TLOAD) && (|DwByteEnable);

    assign w_tload_merged = merge_bytes(r_tload, DwWriteData, DwByteEnable);

    irq_timer u_timer (
        .i_clk         (iCLK),
        .i_rst         (iRST),
        .i_load        (w_wr_tload),
        .i_load_val    (w_tload_merged),
        .i_reload_val  (r_tload),
        .i_enable      (r_tctrl[TCTRL_EN_BIT]),
        .i_auto_reload (r_tctrl[TCTRL_AR_BIT]),
        .o_count       (w_tcount),
        .o_expire      (w_expire)
    );

    // Combinational read mux; registers are read before any same-cycle write
    always_comb begin
        w_rd_data = '0;
        case (w_reg)
            REG_STATUS: w_rd_data[IRQ_N-1:0] = r_pending;
            REG_MASK:   w_rd_data[IRQ_N-1:0] = r_mask;
            REG_MODE:   w_rd_data[IRQ_N-1:0] = r_mode;
            REG_TLOAD:  w_rd_data            = r_tload;
            REG_TCOUNT: w_rd_data            = w_tcount;
            REG_TCTRL:  w_rd_data[1:0]       = r_tctrl;
            default:    w_rd_data            = '0;
        endcase
    end

    assign DwReadData = (DwReadEnable && w_sel) ? w_rd_data : 'z;

    // Edge lines hold until cleared (set wins); level lines follow the
    // synchronized source, with line 7 additionally holding a timer-expiry
    // flag that only CLEAR removes.
    always_comb begin
        w_clr = '0;
        if (w_wr_clear) begin
            w_clr = DwWriteData[IRQ_N-1:0];
        end
        w_rise        = r_sync2 & ~r_dly;
        w_sticky_nxt  = w_expire | (r_exp_sticky & ~w_clr[IRQ_N-1]);
        w_edge_nxt    = (r_pending & ~w_clr) | w_rise | {w_expire, {(IRQ_N-1){1'b0}}};
        w_level_nxt   = r_sync2 | {w_sticky_nxt, {(IRQ_N-1){1'b0}}};
        w_pending_nxt = (r_mode & w_edge_nxt) | (~r_mode & w_level_nxt);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_dly        <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_mode       <= '0;
            r_tload      <= '0;
            r_tctrl      <= '0;
            r_exp_sticky <= 1'b0;
            r_irq_out    <= '0;
        end else begin
            r_sync1      <= iIrqSrc;
            r_sync2      <= r_sync1;
            r_dly        <= r_sync2;
            r_pending    <= w_pending_nxt;
            r_exp_sticky <= w_sticky_nxt;
            r_irq_out    <= r_pending & r_mask;

            if (w_wr_mask) begin
                r_mask <= DwWriteData[IRQ_N-1:0];
            end
            if (w_wr_mode) begin
                r_mode <= DwWriteData[IRQ_N-1:0];
            end
            if (w_wr_tload) begin
                r_tload <= w_tload_merged;
            end
            // A CPU write to TCTRL takes priority over the one-shot auto-disable
            if (w_wr_tctrl) begin
                r_tctrl <= DwWriteData[1:0];
            end else if (w_expire && !r_tctrl[TCTRL_AR_BIT]) begin
                r_tctrl[TCTRL_EN_BIT] <= 1'b0;
            end
        end
    end

    assign oPendingInterrupt = r_irq_out;

endmodule

// File: doc/bus_irq_controller.md
BUS_IRQ_CONTROLLER -- requirements
Module: bus_irq_controller

Interface
REQ-001 The block SHALL have one clock, iCLK; reset iRST is synchronous and active-high.
REQ-002 Parameter BASE_ADDR, default 32'hFF20_0300, SHALL set the base byte address of the 7-word register window.
REQ-003 Ports SHALL be (name direction width meaning):
- iCLK input 1 system clock
- iRST input 1 synchronous active-high reset
- DwReadEnable input 1 CPU data-bus read strobe
- DwWriteEnable input 1 CPU data-bus write strobe
- DwByteEnable input 4 write byte lanes, bit n = DwWriteData[8n+7:8n]
- DwAddress input 32 byte address
- DwWriteData input 32 write data
- DwReadData output 32 read data; 32'hzzzzzzzz when not selected
- iIrqSrc input 8 asynchronous peripheral interrupt lines
- oPendingInterrupt output 8 masked pending interrupts to CPU iPendingInterrupt

Function
REQ-004 Selection SHALL be DwAddress[31:5]==BASE_ADDR[31:5] and DwAddress[4:2]<=6; offsets: 0x00 STATUS (RO, pending[7:0]), 0x04 MASK (RW [7:0]), 0x08 CLEAR (WO, write-1-to-clear), 0x0C MODE (RW [7:0], 1=edge, 0=level), 0x10 TLOAD (RW 32), 0x14 TCOUNT (RO 32), 0x18 TCTRL (RW [1:0], bit0 enable, bit1 auto-reload).
REQ-005 Reads SHALL be combinational: DwReadData valid in the same cycle as DwReadEnable with a selected address; unused bits read 0; CLEAR reads 0.
REQ-006 Writes SHALL take effect at the iCLK edge ending the DwWriteEnable cycle, per byte lane; 8-bit and 2-bit registers use lane 0 only.
REQ-007 Each iIrqSrc bit SHALL pass a 2-flop synchronizer, then a delay flop for rising-edge detection.
REQ-008 Edge-mode pending[i] SHALL set on a synchronized rising edge and clear only by CLEAR write with bit i=1; set wins over clear in the same cycle.
REQ-009 Level-mode pending[i] SHALL equal the synchronized level; CLEAR is ignored for that bit.
REQ-010 Latency: source high before edge E0 -> pending[i]=1 after E2 -> oPendingInterrupt[i]=1 after E3 (if MASK[i]=1).
REQ-011 oPendingInterrupt SHALL be registered: pending & MASK, updated every cycle.
REQ-012 Timer: when TCTRL.enable=1 and TCOUNT!=0, TCOUNT decrements by 1 per cycle; when enable=1 and TCOUNT==0, a one-cycle expiry pulse fires and TCOUNT<=TLOAD if auto-reload, else enable<=0 and TCOUNT stays 0; period = TLOAD+1 cycles.
REQ-013 Timer expiry SHALL set pending[7] regardless of MODE[7]; set wins over a same-cycle CLEAR; in level mode pending[7] = sync level OR expiry sticky until CLEAR.
REQ-014 A TLOAD write SHALL also load TCOUNT with the merged written value, overriding decrement/reload in that cycle.
REQ-015 Writing TCTRL.enable 0 SHALL freeze TCOUNT; re-enable resumes from the frozen value.
REQ-016 Simultaneous DwReadEnable and DwWriteEnable SHALL return pre-write register contents.
REQ-017 Accesses outside the window SHALL not change state; DwReadData stays high-Z.

Reset
REQ-018 On iRST at an iCLK edge, pending, MASK, MODE, TLOAD, TCOUNT, TCTRL, all sync/delay flops and oPendingInterrupt SHALL become 0; iRST overrides any concurrent write.
REQ-019 The cycle after iRST deasserts, a source already high SHALL be seen as a rising edge (delay flop reset to 0).

Structure
REQ-020 Register offsets, BASE_ADDR default and TCTRL bit positions SHALL live in the shared parameter header used by all bus peripherals.
REQ-021 The timer (REQ-012..015) SHALL be a sub-module irq_timer with load/enable/auto-reload inputs and count/expiry outputs.

Verification
REQ-022 Reset, MASK=0xFF, MODE=0xFF, pulse iIrqSrc[2] high 1 cycle -> oPendingInterrupt=0x04 after E3; STATUS read=0x04; write CLEAR=0x04 -> 0x00 next cycle+1.
REQ-023 MODE=0, MASK=0x01, hold iIrqSrc[0] high 10 cycles, CLEAR=0x01 mid-way -> pending stays 1; drops 3 cycles after source falls.
REQ-024 TLOAD=3, TCTRL=0x3 -> expiry every 4 cycles, pending[7] set; TCOUNT reads 3,2,1,0,3 on successive cycles.
REQ-025 TLOAD=2, TCTRL=0x1 -> one expiry, enable reads 0 after; TCOUNT=0 holds.
REQ-026 Edge on source 5 coincident with CLEAR=0x20 -> pending[5]=1; write DwByteEnable=4'b0010 to MASK -> MASK unchanged.
REQ-027 Assert iRST mid-count (TCOUNT=100, pending=0xFF) -> all registers and oPendingInterrupt 0 next cycle; read at DwAddress=BASE_ADDR+0x1C -> high-Z.
